dpsk_uart_tx: RTL and testbench



---
 rtl/dpsk_uart_pkg.sv | 25 ++
 rtl/byte_sync_fifo.sv | 60 ++++++
 rtl/dpsk_uart_tx.sv | 171 +++++++++++++++++
 tb/tb_dpsk_uart_tx.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dpsk_uart_pkg.sv
// Shared types and helpers for the DPSK host-UART transmit path.
// The PARITY state exists in the enum for all builds; it is only reached with UART_PARITY_EN.
package dpsk_uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_t;

    function automatic int unsigned calc_baud_div(input int unsigned clk_freq,
                                                  input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int unsigned calc_baud_cnt_w(input int unsigned baud_div);
        return (baud_div <= 2) ? 1 : $clog2(baud_div);
    endfunction

endpackage

// File: rtl/byte_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; writes while full are ignored.
module byte_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_ok, rd_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A pop in the same cycle does not free space for a write.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_ok && !rd_ok) count_d = count_q + 1'b1;
        else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/dpsk_uart_tx.sv
// Byte FIFO plus 8N1 UART serialiser for the deframer output; drops and flags writes when full.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module dpsk_uart_tx
    import dpsk_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [7:0] deframe_uart_data,
    input  logic       deframe_uart_data_vld,
    output logic       uart_deframe_ready,
    output logic       uart_tx,
    output logic       tx_busy,
    output logic       fifo_overflow
);

    localparam int unsigned BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W    = calc_baud_cnt_w(BAUD_DIV);
    localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(UART_DATA_BITS - 1);

    logic [7:0]    fifo_rd_data;
    logic          fifo_full, fifo_empty, fifo_pop;
    logic [CW-1:0] fifo_count;

    tx_state_t     state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          overflow_q, overflow_d;
    logic          bit_end;
`ifdef UART_PARITY_EN
    logic          par_q, par_d;
`endif

    byte_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst     (rst),
        .wr_en   (deframe_uart_data_vld),
        .wr_data (deframe_uart_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign uart_deframe_ready = (fifo_count != CW'(FIFO_DEPTH));
    assign uart_tx            = tx_q;
    assign tx_busy            = busy_q;
    assign fifo_overflow      = overflow_q;
    assign bit_end            = (baud_q == BAUD_LAST);
    assign overflow_d         = overflow_q | (deframe_uart_data_vld & fifo_full);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
`ifdef UART_PARITY_EN
        par_d    = par_q;
`endif
        if (state_q != StIdle) baud_d = bit_end ? '0 : baud_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                tx_d = UART_IDLE_LEVEL;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rd_data;
`ifdef UART_PARITY_EN
                    par_d    = ^fifo_rd_data;
`endif
                    baud_d   = '0;
                    state_d  = StStart;
                    tx_d     = 1'b0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                        state_d = StParity;
                        tx_d    = par_q;
`else
                        state_d = StStop;
                        tx_d    = UART_IDLE_LEVEL;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shift_q[1];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    tx_d    = UART_IDLE_LEVEL;
                end
            end
            StStop: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rd_data;
`ifdef UART_PARITY_EN
                        par_d    = ^fifo_rd_data;
`endif
                        state_d  = StStart;
                        tx_d     = 1'b0;
                    end else begin
                        state_d = StIdle;
                        tx_d    = UART_IDLE_LEVEL;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = UART_IDLE_LEVEL;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= UART_IDLE_LEVEL;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef UART_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
`ifdef UART_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_dpsk_uart_tx.sv
// Randomised bench for dpsk_uart_tx against a frame-position reference model.
module tb_dpsk_uart_tx;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       vld;
    logic       ready, tx, busy, ovf;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: queued bytes, byte on the line and position within its frame.
    logic [7:0] m_q[$];
    logic [7:0] m_cur;
    bit         m_active;
    int         m_pos;
    bit         m_ovf;

    dpsk_uart_tx #(
        .CLK_FREQ   (4),
        .BAUD_RATE  (1),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sys_clk               (clk),
        .rst                   (rst),
        .deframe_uart_data     (data),
        .deframe_uart_data_vld (vld),
        .uart_deframe_ready    (ready),
        .uart_tx               (tx),
        .tx_busy               (busy),
        .fifo_overflow         (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_active = 0;
        m_pos    = 0;
        m_ovf    = 0;
        m_cur    = '0;
    endfunction

    function automatic void model_edge(input logic v, input logic [7:0] d);
        int         pre_size;
        bit         last;
        bit         pop;
        logic [7:0] nb;
        pre_size = m_q.size();
        last     = m_active && (m_pos == FRAME_CYC - 1);
        pop      = (pre_size > 0) && (!m_active || last);
        nb       = '0;
        if (pop) nb = m_q.pop_front();
        if (v) begin
            if (pre_size < DEPTH) m_q.push_back(d);
            else m_ovf = 1;
        end
        if (m_active && !last) begin
            m_pos++;
        end else if (pop) begin
            m_active = 1;
            m_pos    = 0;
            m_cur    = nb;
        end else begin
            m_active = 0;
        end
    endfunction

    task automatic step(input logic v, input logic [7:0] d);
        vld  = v;
        data = d;
        @(posedge clk);
        model_edge(v, d);
        #1;
        vld = 1'b0;
        check_eq("uart_tx", int'(tx), m_active ? int'(frame_bit(m_cur, m_pos / DIV)) : 1);
        check_eq("tx_busy", int'(busy), int'(m_active));
        check_eq("ready", int'(ready), int'(m_q.size() != DEPTH));
        check_eq("overflow", int'(ovf), int'(m_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    initial begin
        rst  = 1'b1;
        vld  = 1'b0;
        data = '0;
        model_reset();
        #7;
        check_eq("rst_tx", int'(tx), 1);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_ready", int'(ready), 1);
        check_eq("rst_ovf", int'(ovf), 0);
        @(negedge clk);
        rst = 1'b0;

        idle(1000);

        step(1'b1, 8'hA5);
        idle(50);

        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        step(1'b1, 8'h55);
        idle(3 * FRAME_CYC + 10);

        // One byte on the line, then five more writes into a depth-4 FIFO.
        step(1'b1, 8'h11);
        idle(3);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h20 + 8'(i));
        idle(6 * FRAME_CYC + 10);

        // Asynchronous reset during data bit 3 of a frame.
        step(1'b1, 8'h3C);
        idle(17);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("midrst_tx", int'(tx), 1);
        check_eq("midrst_busy", int'(busy), 0);
        check_eq("midrst_ready", int'(ready), 1);
        check_eq("midrst_ovf", int'(ovf), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(100);

        step(1'b1, 8'h07);
        idle(FRAME_CYC + 10);
        step(1'b1, 8'h03);
        idle(FRAME_CYC + 10);

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom));
            idle(DEPTH * FRAME_CYC + 10);
        end

        for (int i = 0; i < 1500; i++) step($urandom_range(0, 15) == 0, 8'($urandom));
        for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom));
        idle((DEPTH + 2) * FRAME_CYC + 10);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
